alu_core: RTL and testbench

- Sequential ALU that sits between the ALU_in and ALU_out interfaces.
- Accepts one operation per handshake on the input side (valid/ready, op, a, b).
- Produces result qualified by a one-cycle done pulse, which is what the ALU_out monitor samples.
- Single-cycle logic/add ops; iterative shift-add multiply.

---
 rtl/alu_core_pkg.sv | 38 +++
 rtl/alu_core_mul.sv | 73 +++++++
 rtl/alu_core.sv | 131 +++++++++++++
 tb/tb_alu_core.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_core_pkg.sv
// Shared types and constants for the alu_core sequential ALU.
// Optional build macro ALU_CORE_MUL_EARLY_TERM_EN is consumed by alu_core_mul.
package alu_core_pkg;

    localparam logic [2:0] OpcNoOp  = 3'd0;
    localparam logic [2:0] OpcAdd   = 3'd1;
    localparam logic [2:0] OpcAnd   = 3'd2;
    localparam logic [2:0] OpcXor   = 3'd3;
    localparam logic [2:0] OpcMul   = 3'd4;
    localparam logic [2:0] OpcRsvd5 = 3'd5;
    localparam logic [2:0] OpcRsvd6 = 3'd6;
    localparam logic [2:0] OpcRstOp = 3'd7;

    typedef enum logic [2:0] {
        OpNoOp  = OpcNoOp,
        OpAdd   = OpcAdd,
        OpAnd   = OpcAnd,
        OpXor   = OpcXor,
        OpMul   = OpcMul,
        OpRsvd5 = OpcRsvd5,
        OpRsvd6 = OpcRsvd6,
        OpRstOp = OpcRstOp
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMul
    } alu_state_t;

    // The product of two operands must fit the result without truncation.
    localparam int unsigned ResultWidthRatio = 2;

    function automatic bit widths_ok(input int unsigned data_w, input int unsigned result_w);
        return result_w == ResultWidthRatio * data_w;
    endfunction

endpackage

// File: rtl/alu_core_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// With ALU_CORE_MUL_EARLY_TERM_EN defined it stops once the remaining multiplier is zero.
module alu_core_mul
    import alu_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned RESULT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    busy,
    output logic [RESULT_WIDTH-1:0] product,
    output logic                    product_valid
);

    logic                    busy_q;
    logic [RESULT_WIDTH-1:0] mcand_q;
    logic [RESULT_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0]   mplier_q;
    logic [RESULT_WIDTH-1:0] partial;
    logic                    last;

    assign partial = mplier_q[0] ? mcand_q : '0;
    // Product includes the current iteration so the final edge can commit it directly.
    assign product       = acc_q + partial;
    assign product_valid = busy_q & last;
    assign busy          = busy_q;

`ifdef ALU_CORE_MUL_EARLY_TERM_EN
    assign last = ((mplier_q >> 1) == '0);
`else
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    logic [CntW-1:0] cnt_q;

    assign last = (cnt_q == CntW'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (busy_q) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            mcand_q  <= RESULT_WIDTH'(a);
            acc_q    <= '0;
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_core.sv
// Sequential ALU: valid/ready op intake, single-cycle add/and/xor, iterative multiply,
// result qualified by a one-cycle done pulse. Optional macro: ALU_CORE_MUL_EARLY_TERM_EN.
module alu_core
    import alu_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned RESULT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [2:0]              op,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    ready,
    output logic                    done,
    output logic [RESULT_WIDTH-1:0] result
);

    if (!widths_ok(DATA_WIDTH, RESULT_WIDTH)) begin : gen_width_check
        $error("alu_core: RESULT_WIDTH must equal 2*DATA_WIDTH");
    end

    alu_state_t              state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    alu_op_t                 op_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q;

    logic                    accept;
    alu_op_t                 op_in;
    logic                    mul_start;
    logic                    mul_busy;
    logic                    mul_valid;
    logic [RESULT_WIDTH-1:0] mul_product;
    logic [DATA_WIDTH:0]     sum;
    logic [RESULT_WIDTH-1:0] exec_result;

    assign accept    = valid & ready_q;
    assign op_in     = alu_op_t'(op);
    assign mul_start = accept & (state_q == StIdle) & (op_in == OpMul);

    alu_core_mul #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESULT_WIDTH (RESULT_WIDTH)
    ) u_mul (
        .clk           (clk),
        .rst           (rst),
        .start         (mul_start),
        .a             (a),
        .b             (b),
        .busy          (mul_busy),
        .product       (mul_product),
        .product_valid (mul_valid)
    );

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        exec_result = '0;
        case (op_q)
            OpAdd:   exec_result = RESULT_WIDTH'(sum);
            OpAnd:   exec_result = RESULT_WIDTH'(a_q & b_q);
            OpXor:   exec_result = RESULT_WIDTH'(a_q ^ b_q);
            default: exec_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (op_in)
                        OpAdd, OpAnd, OpXor: state_d  = StExec;
                        OpMul:               state_d  = StMul;
                        OpRstOp:             result_d = '0;
                        default:             state_d  = StIdle;
                    endcase
                end
            end
            StExec: begin
                result_d = exec_result;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            StMul: begin
                if (mul_valid) begin
                    result_d = mul_product;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else if (!mul_busy) begin
                    // Multiplier idle without a product: recover rather than hang.
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            op_q     <= OpNoOp;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            result_q <= result_d;
            if (accept) begin
                op_q <= op_in;
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_core.sv
// Randomized self-checking bench for alu_core against a behavioural model.
module tb_alu_core;

    localparam int DW = 8;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [2:0]    op;
    logic [DW-1:0] a, b;
    logic          ready, done;
    logic [RW-1:0] result;

    int unsigned   n_checks = 0;
    int unsigned   n_fails  = 0;
    logic [RW-1:0] model_result;

    always #5 clk = ~clk;

    alu_core #(
        .DATA_WIDTH   (DW),
        .RESULT_WIDTH (RW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] ref_calc(input logic [2:0] o, input logic [DW-1:0] x,
                                               input logic [DW-1:0] y, input logic [RW-1:0] prev);
        int unsigned xi = x;
        int unsigned yi = y;
        case (o)
            3'd1:    return RW'(xi + yi);
            3'd2:    return RW'(x & y);
            3'd3:    return RW'(x ^ y);
            3'd4:    return RW'(xi * yi);
            3'd7:    return '0;
            default: return prev;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [DW-1:0] y);
        int msb = -1;
        if (o != 3'd4) return 1;
        for (int i = 0; i < DW; i++) if (y[i]) msb = i;
`ifdef ALU_CORE_MUL_EARLY_TERM_EN
        return (msb < 0) ? 1 : msb + 1;
`else
        return DW;
`endif
    endfunction

    function automatic bit completes(input logic [2:0] o);
        return (o >= 3'd1) && (o <= 3'd4);
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (ready !== 1'b1) check_eq("ready_timeout", 32'(ready), 32'd1);
    endtask

    // Called and returns on a negedge; on return after a completing op we sit in the done cycle.
    task automatic do_op(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
        int n;
        logic [RW-1:0] exp;
        wait_ready();
        exp   = ref_calc(o, x, y, model_result);
        valid = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        if (completes(o)) begin
            n = 0;
            while (done !== 1'b1 && n < 30) begin
                check_eq("busy_ready", 32'(ready), 32'd0);
                check_eq("busy_hold", 32'(result), 32'(model_result));
                // Junk requests while busy must be dropped.
                valid = 1'($urandom_range(0, 1));
                op    = 3'($urandom);
                a     = DW'($urandom);
                b     = DW'($urandom);
                @(negedge clk);
                n++;
            end
            valid = 1'b0;
            check_eq("latency", 32'(n), 32'(ref_latency(o, y)));
            check_eq("result", 32'(result), 32'(exp));
            check_eq("done_ready", 32'(ready), 32'd1);
        end else begin
            valid = 1'b0;
            check_eq("ctl_done", 32'(done), 32'd0);
            check_eq("ctl_ready", 32'(ready), 32'd1);
            check_eq("ctl_result", 32'(result), 32'(exp));
            @(negedge clk);
            check_eq("ctl_done2", 32'(done), 32'd0);
            check_eq("ctl_result2", 32'(result), 32'(exp));
        end
        model_result = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op_tbl [10];
        op_tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd1, 3'd0, 3'd5, 3'd6, 3'd7};

        rst          = 1'b0;
        valid        = 1'b0;
        op           = '0;
        a            = '0;
        b            = '0;
        model_result = '0;
        #2;
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        check_eq("rst_ready_held", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("first_edge_ready", 32'(ready), 32'd1);

        do_op(3'd1, 8'hFF, 8'h01);
        do_op(3'd4, 8'hFF, 8'hFF);
`ifdef ALU_CORE_MUL_EARLY_TERM_EN
        do_op(3'd4, 8'h03, 8'h02);
        do_op(3'd4, 8'h5A, 8'h00);
`endif
        do_op(3'd2, 8'hF0, 8'h3C);
        do_op(3'd3, 8'hAA, 8'h55);
        do_op(3'd2, 8'hF0, 8'h3C);
        do_op(3'd7, 8'h12, 8'h34);
        do_op(3'd3, 8'h0F, 8'h01);
        do_op(3'd5, 8'h11, 8'h22);
        do_op(3'd0, 8'h33, 8'h44);
        do_op(3'd6, 8'h55, 8'h66);

        // Abort a multiply three cycles in.
        wait_ready();
        valid = 1'b1;
        op    = 3'd4;
        a     = 8'h10;
        b     = 8'h10;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_ready", 32'(ready), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_result", 32'(result), 32'd0);
        model_result = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_rel_ready", 32'(ready), 32'd1);
        repeat (10) begin
            check_eq("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        do_op(3'd4, 8'h02, 8'h03);

        for (int i = 0; i < 1000; i++) begin
            logic [2:0]    o;
            logic [DW-1:0] x, y;
            o = op_tbl[$urandom_range(0, 9)];
            x = ($urandom_range(0, 7) == 0) ? 8'hFF : DW'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom);
            do_op(o, x, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
